// File: rtl/pwm_fade_sequencer.sv
// Purpose: per-channel SET/FADE/BREATHE/STOP brightness sequencer feeding pwm duty inputs, shared step prescaler.
// Latency: command effects visible on duty/busy/done one cycle after accept; ramps step once per max(rate,1) ticks.
// Backpressure: cmd_ready drops only on the prescaler tick cycle; a held command is taken on the following cycle.
module pwm_fade_sequencer #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int TICK_DIV = 500_000,
    parameter int RATE_W   = 8,
    parameter int CHAN_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CHAN_W-1:0] cmd_chan,
    input  logic [1:0]        cmd_mode,
    input  logic [DW-1:0]     cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [NCH*DW-1:0] duty,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    localparam logic [1:0] MODE_SET     = 2'b00;
    localparam logic [1:0] MODE_FADE    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam int         PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_BR_UP, ST_BR_DN} state_e;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic          accept;

    assign tick      = (pcnt == PW'(TICK_DIV - 1));
    assign cmd_ready = ~tick;
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

    // A rate of 0 behaves as 1, so the reload value saturates at 0.
    function automatic logic [RATE_W-1:0] reload(input logic [RATE_W-1:0] r);
        return (r == '0) ? '0 : r - RATE_W'(1);
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_e            state;
        logic [DW-1:0]     level;
        logic [DW-1:0]     target;
        logic [RATE_W-1:0] rate;
        logic [RATE_W-1:0] ratecnt;
        logic              done_q;
        logic              hit;
        logic [DW-1:0]     lvl_up;
        logic [DW-1:0]     lvl_dn;

        // Out-of-range channel numbers match no channel, so such commands vanish.
        assign hit    = accept && (cmd_chan == CHAN_W'(c));
        assign lvl_up = level + DW'(1);
        assign lvl_dn = level - DW'(1);

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                level   <= '0;
                target  <= '0;
                rate    <= '0;
                ratecnt <= '0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (hit) begin
                    target  <= cmd_target;
                    rate    <= cmd_rate;
                    ratecnt <= reload(cmd_rate);
                    case (cmd_mode)
                        MODE_SET: begin
                            level  <= cmd_target;
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                        MODE_FADE: begin
                            if (cmd_target == level) begin
                                state  <= ST_IDLE;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_RAMP;
                            end
                        end
                        MODE_BREATHE: state <= ST_BR_UP;
                        default:      state <= ST_IDLE;
                    endcase
                end else if (tick && (state != ST_IDLE)) begin
                    if (ratecnt != '0) begin
                        ratecnt <= ratecnt - RATE_W'(1);
                    end else begin
                        ratecnt <= reload(rate);
                        case (state)
                            ST_RAMP: begin
                                if (level < target) begin
                                    level <= lvl_up;
                                    if (lvl_up == target) begin
                                        state  <= ST_IDLE;
                                        done_q <= 1'b1;
                                    end
                                end else begin
                                    level <= lvl_dn;
                                    if (lvl_dn == target) begin
                                        state  <= ST_IDLE;
                                        done_q <= 1'b1;
                                    end
                                end
                            end
                            ST_BR_UP: begin
                                // Above the peak (after preemption) head down first; peak 0 sits at 0.
                                if (level < target) begin
                                    level <= lvl_up;
                                    if (lvl_up == target) state <= ST_BR_DN;
                                end else if (level != '0) begin
                                    level <= lvl_dn;
                                    state <= (lvl_dn == '0) ? ST_BR_UP : ST_BR_DN;
                                end
                            end
                            ST_BR_DN: begin
                                if (level != '0) begin
                                    level <= lvl_dn;
                                    if (lvl_dn == '0) state <= ST_BR_UP;
                                end else begin
                                    state <= ST_BR_UP;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            end
        end

        assign duty[c*DW +: DW] = level;
        assign busy[c]          = (state != ST_IDLE);
        assign done[c]          = done_q;
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer with a 4-cycle tick; expected values are hand-derived,
// and tick timing comes from a local prescaler counter driven by the same reset.
module tb_pwm_fade_sequencer;

    localparam int NCH      = 4;
    localparam int DW       = 8;
    localparam int TICK_DIV = 4;
    localparam int RATE_W   = 8;
    localparam int CHAN_W   = 3;

    localparam logic [1:0] M_SET     = 2'b00;
    localparam logic [1:0] M_FADE    = 2'b01;
    localparam logic [1:0] M_BREATHE = 2'b10;
    localparam logic [1:0] M_STOP    = 2'b11;

    logic              sys_clk    = 1'b0;
    logic              rst_n      = 1'b0;
    logic              cmd_valid  = 1'b0;
    logic              cmd_ready;
    logic [CHAN_W-1:0] cmd_chan   = '0;
    logic [1:0]        cmd_mode   = '0;
    logic [DW-1:0]     cmd_target = '0;
    logic [RATE_W-1:0] cmd_rate   = '0;
    logic [NCH*DW-1:0] duty;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    int n_checks = 0;
    int n_errors = 0;
    int tb_pcnt;

    int prev, nsteps, ndone, done_at, ticks, first_ticks, align, k, bad, dn, found;
    int step_cyc[4];
    int step_val[4];
    logic [7:0]        br_pat[4];
    logic [NCH*DW-1:0] snap_duty;
    logic [NCH-1:0]    snap_busy;

    pwm_fade_sequencer #(
        .NCH(NCH), .DW(DW), .TICK_DIV(TICK_DIV), .RATE_W(RATE_W), .CHAN_W(CHAN_W)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_mode(cmd_mode),
        .cmd_target(cmd_target), .cmd_rate(cmd_rate),
        .duty(duty), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) tb_pcnt <= 0;
        else        tb_pcnt <= (tb_pcnt == TICK_DIV - 1) ? 0 : tb_pcnt + 1;
    end

    function automatic logic [7:0] chd(input int c);
        return duty[c*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; returns at the negedge following the accepting posedge.
    task automatic send_cmd(input logic [CHAN_W-1:0] ch, input logic [1:0] mode,
                            input logic [7:0] tgt, input logic [7:0] rate);
        cmd_chan   = ch;
        cmd_mode   = mode;
        cmd_target = tgt;
        cmd_rate   = rate;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge sys_clk);
        if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        br_pat = '{8'd1, 8'd2, 8'd1, 8'd0};

        repeat (3) @(negedge sys_clk);
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // 1: reset in the middle of a fade
        send_cmd(0, M_FADE, 8'hFF, 8'd1);
        repeat (20) @(negedge sys_clk);
        check("t1_busy_pre", busy[0], 1);
        check("t1_moving", chd(0) != 8'd0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_duty", duty, 0);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_ready", cmd_ready, 1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("t1_duty_after", duty, 0);

        // 2: SET
        send_cmd(1, M_SET, 8'h80, 8'd0);
        check("t2_duty", chd(1), 8'h80);
        check("t2_done", done[1], 1);
        check("t2_busy", busy[1], 0);
        @(negedge sys_clk);
        check("t2_done_off", done[1], 0);
        check("t2_duty_hold", chd(1), 8'h80);

        // 3: FADE 0 -> 3 at rate 2
        send_cmd(0, M_FADE, 8'd3, 8'd2);
        check("t3_busy", busy[0], 1);
        check("t3_level0", chd(0), 0);
        prev = chd(0); nsteps = 0; ndone = 0; done_at = -1; ticks = 0; first_ticks = -1; align = -1;
        for (int i = 0; i < 4; i++) begin step_cyc[i] = -1; step_val[i] = -1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (tb_pcnt == 0) ticks++;
            if (int'(chd(0)) != prev) begin
                if (nsteps < 4) begin step_cyc[nsteps] = i; step_val[nsteps] = int'(chd(0)); end
                if (nsteps == 0) begin first_ticks = ticks; align = tb_pcnt; end
                nsteps++;
                prev = int'(chd(0));
            end
            if (done[0]) begin ndone++; done_at = i; end
        end
        check("t3_nsteps", nsteps, 3);
        check("t3_step1", step_val[0], 1);
        check("t3_step2", step_val[1], 2);
        check("t3_step3", step_val[2], 3);
        check("t3_first_ticks", first_ticks, 2);
        check("t3_tick_align", align, 0);
        check("t3_period_a", step_cyc[1] - step_cyc[0], 8);
        check("t3_period_b", step_cyc[2] - step_cyc[1], 8);
        check("t3_ndone", ndone, 1);
        check("t3_done_at", done_at, step_cyc[2]);
        check("t3_busy_end", busy[0], 0);

        // 4: BREATHE peak 2 at rate 1
        send_cmd(2, M_BREATHE, 8'd2, 8'd1);
        k = 0; bad = 0; dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (!busy[2]) bad++;
            if (done[2]) dn++;
            if (tb_pcnt == 0) begin
                if (k < 8) check($sformatf("t4_br_%0d", k), chd(2), br_pat[k % 4]);
                k++;
            end
        end
        check("t4_busy", bad, 0);
        check("t4_done", dn, 0);

        // 5: FADE to 0xFF, STOP at level 5
        send_cmd(0, M_FADE, 8'hFF, 8'd1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (chd(0) == 8'd5) begin found = 1; break; end
        end
        check("t5_reach5", found, 1);
        send_cmd(0, M_STOP, 8'd0, 8'd0);
        check("t5_level", chd(0), 5);
        check("t5_busy", busy[0], 0);
        bad = 0; dn = 0;
        for (int i = 0; i < 100 * TICK_DIV; i++) begin
            @(negedge sys_clk);
            if (chd(0) != 8'd5) bad++;
            if (done[0]) dn++;
        end
        check("t5_hold", bad, 0);
        check("t5_no_done", dn, 0);
        check("t5_busy_end", busy[0], 0);

        // 6: command held into the tick cycle, then an out-of-range channel
        found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (tb_pcnt == TICK_DIV - 1) begin found = 1; break; end
        end
        check("t6_find_tick", found, 1);
        check("t6_ready_low", cmd_ready, 0);
        cmd_chan = 3; cmd_mode = M_SET; cmd_target = 8'h42; cmd_rate = 8'd0; cmd_valid = 1'b1;
        @(negedge sys_clk);
        check("t6_not_taken", chd(3), 0);
        check("t6_ready_back", cmd_ready, 1);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        check("t6_taken", chd(3), 8'h42);
        check("t6_done", done[3], 1);

        send_cmd(2, M_STOP, 8'd0, 8'd0);
        check("t6_br_stopped", busy[2], 0);
        snap_duty = duty;
        snap_busy = busy;
        send_cmd(7, M_SET, 8'h11, 8'd0);
        check("t6_oor_duty", duty, snap_duty);
        check("t6_oor_busy", busy, snap_busy);
        check("t6_oor_done", done, 0);
        repeat (2 * TICK_DIV) @(negedge sys_clk);
        check("t6_oor_duty_later", duty, snap_duty);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
